// File: rtl/control_rampa_pwm.sv
// Soft-start/soft-stop ramp for a PWM duty code: steps the duty one code per DIV_PASO clocks
// toward a clamped target, with a latched emergency stop.
module control_rampa_pwm #(
  parameter int unsigned DIV_PASO = 50000,
  parameter int unsigned VEL_MAX  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       habilitar,
  input  logic [3:0] velocidad_objetivo,
  input  logic       paro,
  output logic [3:0] velocidad,
  output logic [1:0] estado,
  output logic       en_objetivo,
  output logic       ocupado,
  output logic       falla
);

  localparam int unsigned CntW = (DIV_PASO > 1) ? $clog2(DIV_PASO) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV_PASO - 1);
  localparam logic [3:0] VelMax = 4'(VEL_MAX);

  typedef enum logic [1:0] {
    StReposo   = 2'b00,
    StSubiendo = 2'b01,
    StEstable  = 2'b10,
    StBajando  = 2'b11
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [3:0]      vel_q, vel_d;
  logic [CntW-1:0] cuenta_q, cuenta_d;
  logic            falla_q, falla_d;
  logic [3:0]      objetivo;
  logic            paso;

  always_comb begin
    objetivo = 4'd0;
    if (habilitar && !falla_q) begin
      objetivo = (velocidad_objetivo > VelMax) ? VelMax : velocidad_objetivo;
    end
  end

  assign paso = (cuenta_q == CntMax);

  always_comb begin
    vel_d    = vel_q;
    cuenta_d = paso ? '0 : cuenta_q + CntW'(1);
    falla_d  = falla_q;
    estado_d = estado_q;

    // Idle with nothing to do: keep the step grid parked so a new ramp gets a full first step.
    if (estado_q == StReposo && objetivo == 4'd0) begin
      cuenta_d = '0;
    end

    if (paso) begin
      if (vel_q < objetivo) begin
        vel_d = vel_q + 4'd1;
      end else if (vel_q > objetivo) begin
        vel_d = vel_q - 4'd1;
      end
    end

    if (vel_d < objetivo) begin
      estado_d = StSubiendo;
    end else if (vel_d > objetivo) begin
      estado_d = StBajando;
    end else if (vel_d == 4'd0) begin
      estado_d = StReposo;
    end else begin
      estado_d = StEstable;
    end

    if (!habilitar) begin
      falla_d = 1'b0;
    end

    // Emergency stop wins over everything else on the same edge.
    if (paro) begin
      vel_d    = 4'd0;
      cuenta_d = '0;
      falla_d  = 1'b1;
      estado_d = StReposo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_q    <= 4'd0;
      cuenta_q <= '0;
      falla_q  <= 1'b0;
      estado_q <= StReposo;
    end else begin
      vel_q    <= vel_d;
      cuenta_q <= cuenta_d;
      falla_q  <= falla_d;
      estado_q <= estado_d;
    end
  end

  assign velocidad   = vel_q;
  assign estado      = estado_q;
  assign falla       = falla_q;
  assign en_objetivo = (estado_q == StEstable);
  assign ocupado     = (estado_q == StSubiendo) || (estado_q == StBajando);

endmodule
